// File: rtl/iob_timer_alarm_if.sv
// CPU register bus shared with the timer: valid/write/addr/data_in request, registered data_out/ready response.
// The slave answers every request one cycle later and cannot stall.
interface iob_timer_alarm_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic                     valid;
    logic                     write;
    logic [2:0]               addr;
    logic [COUNTER_WIDTH-1:0] data_in;
    logic [COUNTER_WIDTH-1:0] data_out;
    logic                     ready;

    modport master (
        output valid, write, addr, data_in,
        input  data_out, ready
    );

    modport slave (
        input  valid, write, addr, data_in,
        output data_out, ready
    );
endinterface

// File: rtl/iob_timer_alarm.sv
// Compare/alarm stage behind the free-running timer: match count_in against CMP, one-shot or auto-reload.
// fire/pending/irq appear one cycle after the matching count; bus acks after 1 cycle, never stalls.
module iob_timer_alarm #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] i_count_in,
    iob_timer_alarm_if.slave         bus,
    output logic                     o_irq,
    output logic                     o_fire
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [1:0]               r_state;
    logic                     r_en;
    logic                     r_periodic;
    logic                     r_irq_en;
    logic [COUNTER_WIDTH-1:0] r_cmp;
    logic [COUNTER_WIDTH-1:0] r_period;
    logic                     r_pending;
    logic                     r_ready;
    logic [COUNTER_WIDTH-1:0] r_data_out;
    logic                     r_irq;
    logic                     r_fire;

    logic                     w_wr;
    logic                     w_rd;
    logic                     w_wr_ctrl;
    logic                     w_wr_cmp;
    logic                     w_wr_period;
    logic                     w_wr_status;
    logic                     w_disable;
    logic                     w_match;
    logic                     w_hit;
    logic                     w_reload;
    logic [1:0]               w_state_nxt;
    logic [COUNTER_WIDTH-1:0] w_cmp_nxt;
    logic                     w_pending_nxt;
    logic                     w_irq_en_nxt;
    logic [COUNTER_WIDTH-1:0] w_rd_dat;

    always_comb begin
        w_wr        = bus.valid & bus.write;
        w_rd        = bus.valid & ~bus.write;
        w_wr_ctrl   = w_wr && (bus.addr == 3'd0);
        w_wr_cmp    = w_wr && (bus.addr == 3'd1);
        w_wr_period = w_wr && (bus.addr == 3'd2);
        w_wr_status = w_wr && (bus.addr == 3'd3);
        w_disable   = w_wr_ctrl && !bus.data_in[0];
        // A disabling CTRL write suppresses a coincident match entirely.
        w_match     = (r_state == ST_ARMED) && (i_count_in == r_cmp);
        w_hit       = w_match && !w_disable;
        w_reload    = w_hit && r_periodic && (r_period != '0);

        w_state_nxt = r_state;
        if (w_disable)
            w_state_nxt = ST_IDLE;
        else if (w_wr_ctrl || (w_wr_cmp && r_en))
            w_state_nxt = ST_ARMED;
        else if (w_hit)
            w_state_nxt = w_reload ? ST_ARMED : ST_FIRED;

        // An explicit CMP write overrides the auto-reload of a coincident match.
        w_cmp_nxt = r_cmp;
        if (w_wr_cmp)
            w_cmp_nxt = bus.data_in;
        else if (w_reload)
            w_cmp_nxt = r_cmp + r_period;

        w_pending_nxt = r_pending;
        if (w_hit)
            w_pending_nxt = 1'b1;
        else if (w_wr_status && bus.data_in[0])
            w_pending_nxt = 1'b0;

        w_irq_en_nxt = w_wr_ctrl ? bus.data_in[2] : r_irq_en;

        w_rd_dat = '0;
        case (bus.addr)
            3'd0:    w_rd_dat = {{(COUNTER_WIDTH-3){1'b0}}, r_irq_en, r_periodic, r_en};
            3'd1:    w_rd_dat = r_cmp;
            3'd2:    w_rd_dat = r_period;
            3'd3:    w_rd_dat = {{(COUNTER_WIDTH-2){1'b0}}, (r_state == ST_ARMED), r_pending};
            3'd4:    w_rd_dat = i_count_in;
            default: w_rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_cmp      <= '0;
            r_period   <= '0;
            r_pending  <= 1'b0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
            r_irq      <= 1'b0;
            r_fire     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmp     <= w_cmp_nxt;
            r_pending <= w_pending_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_irq     <= w_pending_nxt & w_irq_en_nxt;
            r_fire    <= w_hit;
            r_ready   <= bus.valid;
            if (w_wr_ctrl) begin
                r_en       <= bus.data_in[0];
                r_periodic <= bus.data_in[1];
            end
            if (w_wr_period)
                r_period <= bus.data_in;
            if (w_rd)
                r_data_out <= w_rd_dat;
        end
    end

    assign bus.ready    = r_ready;
    assign bus.data_out = r_data_out;
    assign o_irq        = r_irq;
    assign o_fire       = r_fire;
endmodule

// File: doc/iob_timer_alarm.md
Name: iob_timer_alarm

Overview:
- Compare/alarm stage directly downstream of the free-running timer counter.
- Consumes the timer's counter value every cycle and compares it against a CPU-programmed compare register.
- On a match, raises a sticky pending flag, a level interrupt, and a one-cycle fire pulse. Supports one-shot and periodic (auto-reload) modes.
- Sits on the same simple CPU bus as the timer (valid/ready, addr, data_in/data_out).

Parameters:
- COUNTER_WIDTH, 32: width of the consumed counter value, the compare register and the period register; also the bus data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- count_in  in  COUNTER_WIDTH  current timer counter value (increments by 1 per cycle, may be reset to 0 at any time)
- valid  in  1  bus request
- write  in  1  1 = write, 0 = read; sampled with valid
- addr  in  3  register select
- data_in  in  COUNTER_WIDTH  write data
- data_out  out  COUNTER_WIDTH  read data, registered, valid when ready=1
- ready  out  1  bus acknowledge
- irq  out  1  level interrupt = pending & irq_en, registered
- fire  out  1  one-cycle pulse on each match

Behaviour:
- Everything is synchronous to clk. On rst: all registers 0, state IDLE, ready=0, data_out=0, irq=0, fire=0.
- Register map:
  - addr 0 CTRL: bit0 en, bit1 periodic, bit2 irq_en.
  - addr 1 CMP.
  - addr 2 PERIOD.
  - addr 3 STATUS: bit0 pending (read; write-1-to-clear), bit1 armed (read-only).
  - addr 4 COUNT: read-only snapshot of count_in.
  - addr 5-7 read 0; writes to them are ignored.
- Bus handshake:
  - ready <= valid each cycle, giving 1-cycle latency.
  - data_out is loaded in the same edge with the addressed register value on a read; it holds its value otherwise.
  - Writes take effect at the edge where valid & write = 1.
  - Back-to-back requests on consecutive cycles are allowed.
- State machine:
  - IDLE -> ARMED: on a CTRL write with en=1, or a CMP write while en=1.
  - ARMED -> FIRED: on a match (count_in == CMP), one-shot mode.
  - ARMED -> ARMED: on a match in periodic mode with PERIOD != 0; CMP <= CMP + PERIOD, mod 2^COUNTER_WIDTH, so wrap-around is natural.
  - Periodic mode with PERIOD == 0 behaves as one-shot.
  - FIRED -> ARMED: on a CMP write while en=1.
  - Any state -> IDLE: on a CTRL write with en=0.
- Match: evaluated only in ARMED, as an equality compare on count_in registered in the same cycle. A match at edge t sets pending=1 and fire=1 at t+1, and irq=1 at t+1 if irq_en.
- fire is high for exactly one cycle per match.
- Simultaneous events:
  - STATUS clear write and a new match in the same cycle: pending stays 1 (set wins).
  - CMP write and a match in the same cycle: the match is honoured with the old CMP; the written CMP value then overrides any auto-reload and the block stays ARMED.
  - CTRL en=0 write and a match in the same cycle: no fire, go IDLE.
- count_in jumps (timer soft reset): no special handling. A passed compare value is simply not matched until the counter reaches it again.
- Changing irq_en affects irq on the next cycle; pending is not altered.
- rst mid-operation returns to reset values on the next edge, regardless of bus activity; a request in flight is dropped and ready=0.

Test Plan:
1. Reset, then read all addresses 0-4 -> each read yields ready one cycle after valid and data_out=0, except COUNT, which returns count_in.
2. One-shot: write CMP=100, then CTRL=0b101; drive count_in 95..105 -> fire=1 exactly one cycle after count_in=100, irq=1 from then on, STATUS=0b01 (pending, not armed); no second fire.
3. Periodic: CMP=10, PERIOD=5, CTRL=0b111; count_in 0..40 -> fires after counts 10, 15, 20, 25, 30, 35, 40; CMP reads 45 at the end.
4. Wrap-around: CMP=0xFFFF_FFFE, PERIOD=4, periodic; count_in 0xFFFF_FFFC..0x0000_0003 -> fires at 0xFFFF_FFFE and 0x0000_0002; CMP=0x0000_0006.
5. Clear/set collision: with pending=1, write STATUS=1 on the same cycle as a periodic match -> pending stays 1, irq stays 1; a clear in a non-match cycle -> pending=0, irq=0 next cycle.
6. Assert rst while ARMED with a read outstanding -> next cycle ready=0, irq=0, CTRL=0, state IDLE; a later match of the old CMP value produces no fire.
